tri_bus_arbiter: RTL and testbench

- Parametrised, registered-enable tristate bus driver for N channels sharing one WIDTH-bit inout bus. Next generation of the single bufif1 buffer gate.
- Adds round-robin ownership, a bounded hold time and enforced turnaround (all-off) cycles, so two channels never drive simultaneously.
- Sits between channel producers and a shared on-board/bidirectional data bus. Also returns a registered sample of the bus.

---
 rtl/tri_bus_pkg.sv | 27 ++
 rtl/tri_bus_arbiter_rr_pick.sv | 45 ++++
 rtl/tri_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_tri_bus_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_bus_pkg.sv
// Shared definitions for the tristate bus arbiter family: FSM encoding and
// a constant-width helper used to size counters and pointers.
package tri_bus_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_DRIVE = ST_DRIVE,
        S_TURN  = ST_TURN
    } state_e;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Combinational N-way round-robin picker: the first requester strictly after
// i_ptr (wrapping) wins, so the previous winner ends up at lowest priority.
module rr_pick
    import tri_bus_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [PW-1:0] o_index,
    output logic          o_any
);

    logic [2*N-1:0] w_req2;
    logic [2*N-1:0] w_oh2;
    logic [PW:0]    w_pos;
    logic           w_found;

    // Scan a doubled request vector so the wrap needs no modulo arithmetic.
    always_comb begin
        w_req2  = {i_req, i_req};
        w_oh2   = {(2*N){1'b0}};
        w_found = 1'b0;
        w_pos   = {(PW+1){1'b0}};
        for (int k = 1; k <= N; k++) begin
            w_pos        = {1'b0, i_ptr} + (PW+1)'(k);
            w_oh2[w_pos] = w_req2[w_pos] & ~w_found;
            w_found      = w_found | w_req2[w_pos];
        end
    end

    assign o_onehot = w_oh2[N-1:0] | w_oh2[2*N-1:N];
    assign o_any    = w_found;

    // Encode the folded one-hot winner into an index.
    always_comb begin
        o_index = {PW{1'b0}};
        for (int i = 0; i < N; i++) begin
            o_index = o_index | (o_onehot[i] ? PW'(i) : {PW{1'b0}});
        end
    end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin tristate bus owner with bounded hold and all-off turnaround.
// Optional macro TRI_BUS_KEEPER_EN: adds ext_drive and keeps rdata off Z/X.
module tri_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int N        = 4,
    parameter int TURN     = 1,
    parameter int HOLD_MAX = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   wdata,
`ifdef TRI_BUS_KEEPER_EN
    input  logic                 ext_drive,
`endif
    output logic [N-1:0]         grant,
    inout  wire  [WIDTH-1:0]     bus,
    output logic                 bus_oe,
    output logic [WIDTH-1:0]     rdata,
    output logic                 busy
);

    localparam int PW = clog2(N);
    localparam int HW = clog2(HOLD_MAX + 1);
    localparam int TW = clog2(TURN + 1);

    state_e          r_state;
    logic [N-1:0]    r_grant;
    logic            r_oe;
    logic            r_busy;
    logic [PW-1:0]   r_ptr;
    logic [HW-1:0]   r_hold;
    logic [TW-1:0]   r_turn;
    logic [WIDTH-1:0] r_rdata;

    logic [N-1:0]     w_onehot;
    logic [PW-1:0]    w_index;
    logic             w_any;
    logic [HW-1:0]    w_hold_inc;
    logic [WIDTH-1:0] w_drive;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_onehot),
        .o_index  (w_index),
        .o_any    (w_any)
    );

    assign w_hold_inc = r_hold + {{(HW-1){1'b0}}, 1'b1};

    // The pointer doubles as the owner index while in DRIVE.
    assign w_drive = wdata[int'(r_ptr)*WIDTH +: WIDTH];
    assign bus     = r_oe ? w_drive : {WIDTH{1'bz}};

    // Ownership FSM: arbitrate in IDLE only, release on drop or hold expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= {N{1'b0}};
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_ptr   <= PW'(N - 1);
            r_hold  <= {HW{1'b0}};
            r_turn  <= {TW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state <= S_DRIVE;
                        r_grant <= w_onehot;
                        r_oe    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_ptr   <= w_index;
                        r_hold  <= {HW{1'b0}};
                    end
                end
                S_DRIVE: begin
                    if (!req[r_ptr] || (w_hold_inc == HW'(HOLD_MAX))) begin
                        r_state <= S_TURN;
                        r_grant <= {N{1'b0}};
                        r_oe    <= 1'b0;
                        r_hold  <= {HW{1'b0}};
                        r_turn  <= {TW{1'b0}};
                    end else begin
                        r_hold  <= w_hold_inc;
                    end
                end
                S_TURN: begin
                    if (r_turn == TW'(TURN - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_turn  <= {TW{1'b0}};
                    end else begin
                        r_turn  <= r_turn + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= {N{1'b0}};
                    r_oe    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_hold  <= {HW{1'b0}};
                    r_turn  <= {TW{1'b0}};
                end
            endcase
        end
    end

    // Bus sample; the keeper variant only captures cycles with an active driver.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= {WIDTH{1'b0}};
        end else begin
`ifdef TRI_BUS_KEEPER_EN
            if (r_oe || ext_drive) begin
                r_rdata <= bus;
            end
`else
            r_rdata <= bus;
`endif
        end
    end

    assign grant  = r_grant;
    assign bus_oe = r_oe;
    assign busy   = r_busy;
    assign rdata  = r_rdata;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Self-checking bench for tri_bus_arbiter: directed scenarios plus random
// requests compared against a cycle-level ownership model.
module tb_tri_bus_arbiter;

    localparam int WIDTH    = 8;
    localparam int N        = 4;
    localparam int TURN     = 1;
    localparam int HOLD_MAX = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] wdata;
    logic [N-1:0]       grant;
    wire  [WIDTH-1:0]   bus;
    logic               bus_oe;
    logic [WIDTH-1:0]   rdata;
    logic               busy;
`ifdef TRI_BUS_KEEPER_EN
    logic               ext_drive = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    // reference model state: owner -1 means nobody drives
    int               m_owner;
    int               m_gap;
    int               m_ptr;
    int               m_held;
    logic [WIDTH-1:0] m_rdata;
    bit               m_rd_known;

    int owners[$];
    int lens[$];
    int gaps[$];

    always #5 clk = ~clk;

    tri_bus_arbiter #(
        .WIDTH    (WIDTH),
        .N        (N),
        .TURN     (TURN),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .wdata  (wdata),
`ifdef TRI_BUS_KEEPER_EN
        .ext_drive (ext_drive),
`endif
        .grant  (grant),
        .bus    (bus),
        .bus_oe (bus_oe),
        .rdata  (rdata),
        .busy   (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        m_owner    = -1;
        m_gap      = 0;
        m_ptr      = N - 1;
        m_held     = 0;
        m_rdata    = '0;
        m_rd_known = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req   = '0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_oe",    32'(bus_oe), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // one clock: advance the model on the inputs seen at the edge, then compare
    task automatic step();
        bit found;
        @(posedge clk);
        if (m_owner >= 0) begin
            m_rdata    = wdata[m_owner*WIDTH +: WIDTH];
            m_rd_known = 1'b1;
        end else begin
`ifndef TRI_BUS_KEEPER_EN
            m_rd_known = 1'b0;
`endif
        end
        if (m_owner >= 0) begin
            m_held++;
            if (!req[m_owner] || m_held == HOLD_MAX) begin
                m_owner = -1;
                m_gap   = TURN;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (req != '0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!found && req[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_ptr   = c;
                    m_held  = 0;
                end
            end
        end
        #1;
        chk("grant",   32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("bus_oe",  32'(bus_oe), 32'(m_owner >= 0));
        chk("busy",    32'(busy), 32'(m_owner >= 0 || m_gap > 0));
        chk("onehot0", 32'($onehot0(grant)), 32'd1);
        if (m_owner >= 0) chk("bus", 32'(bus), 32'(wdata[m_owner*WIDTH +: WIDTH]));
        if (m_rd_known)   chk("rdata", 32'(rdata), 32'(m_rdata));
    endtask

    // run n cycles, recording owner order, grant lengths and zero-grant gaps
    task automatic run_record(input int n);
        logic [N-1:0] prev;
        int len;
        int zrun;
        owners.delete(); lens.delete(); gaps.delete();
        prev = '0; len = 0; zrun = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (grant != '0) begin
                if (prev == '0) begin
                    owners.push_back(oh2idx(grant));
                    if (owners.size() > 1) gaps.push_back(zrun);
                    len = 0;
                end
                len++;
            end else begin
                if (prev != '0) begin
                    lens.push_back(len);
                    zrun = 0;
                end
                zrun++;
            end
            prev = grant;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        wdata = '0;
        model_reset();
        #23;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_oe",    32'(bus_oe), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // single channel: one-cycle grant latency, rdata one cycle later
        wdata[7:0] = 8'hA5;
        req = 4'b0001;
        step();
        chk("t1_oe",  32'(bus_oe), 32'd1);
        chk("t1_bus", 32'(bus), 32'h0000_00A5);
        step();
        chk("t1_rdata", 32'(rdata), 32'h0000_00A5);
        req = 4'b0000;
        step();
        chk("t1_release", 32'(bus_oe), 32'd0);
        for (int i = 0; i < 4; i++) step();

        // all requesting: strict rotation with HOLD_MAX runs and TURN+1 gaps
        do_reset();
        wdata = 32'h4433_2211;
        req   = 4'b1111;
        run_record(95);
        chk("t2_count", 32'(owners.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) chk("t2_order", 32'(owners[i]), 32'(i % N));
        for (int i = 0; i < 4; i++) chk("t2_len", 32'(lens[i]), 32'(HOLD_MAX));
        for (int i = 0; i < 4; i++) chk("t2_gap", 32'(gaps[i]), 32'(TURN + 1));

        // lone requester held: released at expiry and re-granted after the gap
        do_reset();
        req = 4'b0100;
        run_record(40);
        chk("t3_count", 32'(owners.size() >= 2), 32'd1);
        chk("t3_own0",  32'(owners[0]), 32'd2);
        chk("t3_own1",  32'(owners[1]), 32'd2);
        chk("t3_len",   32'(lens[0]), 32'(HOLD_MAX));
        chk("t3_gap",   32'(gaps[0]), 32'(TURN + 1));

        // asynchronous reset between edges while driving
        do_reset();
        req = 4'b0010;
        step();
        step();
        chk("t4_driving", 32'(bus_oe), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t4_async_oe",    32'(bus_oe), 32'd0);
        chk("t4_async_grant", 32'(grant), 32'd0);
        chk("t4_async_busy",  32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1111;
        step();
        chk("t4_restart", 32'(grant), 32'd1);
        for (int i = 0; i < 20; i++) step();

`ifdef TRI_BUS_KEEPER_EN
        // keeper: last driven value survives the undriven cycles
        do_reset();
        wdata[7:0] = 8'h3C;
        req = 4'b0001;
        step();
        step();
        req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_keep", 32'(rdata), 32'h0000_003C);
        end
`endif

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step();
            wdata = $urandom;
            if ($urandom_range(0, 7) == 0) req = N'($urandom_range(0, 15));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
